// File: rtl/fifo_rd_checker.sv
// Read-side FIFO consumer: waits for almost_full, drains in bursts, checks an incrementing-byte stream.
// Latency: rd_en -> dout_vld is 2 cycles. Backpressure: rd_en is gated by empty, so the FIFO never underflows.
// Optional FIFO_CHK_TIMEOUT_EN adds a fill-wait watchdog that forces a drain and sets a sticky timeout flag.
module fifo_rd_checker #(
  parameter int DATA_W      = 8,
  parameter int ERR_CNT_W   = 16,
  parameter int BURST_MAX   = 16,
  parameter int COOL_CYC    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_50M,
  input  logic                 rst,
  input  logic                 almost_full,
  input  logic                 almost_empty,
  input  logic                 empty,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 rd_en,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_vld,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          byte_cnt,
  output logic                 timeout
);

  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam int CC_W = $clog2(COOL_CYC + 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);
  localparam logic [CC_W-1:0] COOL_LAST  = CC_W'(COOL_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FULL, READ, COOL} state_t;

  state_t            state;
  logic              rd_req;
  logic [BC_W-1:0]   burst_cnt;
  logic [CC_W-1:0]   cool_cnt;
  logic              af_m;
  logic              af_s;
  logic              rd_vld_d1;
  logic              lock;
  logic [DATA_W-1:0] exp_byte;

`ifdef FIFO_CHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // almost_full comes from the write clock domain
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      af_m <= 1'b0;
      af_s <= 1'b0;
    end else begin
      af_m <= almost_full;
      af_s <= af_m;
    end
  end

  assign rd_en = rd_req & ~empty;

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      burst_cnt <= '0;
      cool_cnt  <= '0;
`ifdef FIFO_CHK_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef FIFO_CHK_TIMEOUT_EN
      if (state != WAIT_FULL) wd_cnt <= '0;
`endif
      case (state)
        IDLE: state <= WAIT_FULL;
        WAIT_FULL: begin
          if (af_s) begin
            state     <= READ;
            rd_req    <= 1'b1;
            burst_cnt <= '0;
          end
`ifdef FIFO_CHK_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            timeout   <= 1'b1;
            state     <= READ;
            rd_req    <= 1'b1;
            burst_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        READ: begin
          if (rd_en) burst_cnt <= burst_cnt + BC_W'(1);
          // all exit causes share one transition, so a coincident almost_empty and burst end count once
          if (almost_empty || empty || (rd_en && burst_cnt == BURST_LAST)) begin
            state    <= COOL;
            rd_req   <= 1'b0;
            cool_cnt <= '0;
          end
        end
        COOL: begin
          if (cool_cnt == COOL_LAST) state <= WAIT_FULL;
          else                       cool_cnt <= cool_cnt + CC_W'(1);
        end
        default: begin
          state  <= IDLE;
          rd_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      rd_vld_d1 <= 1'b0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      lock      <= 1'b0;
      exp_byte  <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      rd_vld_d1 <= rd_en;
      dout_vld  <= rd_vld_d1;
      if (rd_vld_d1) begin
        dout     <= rd_data;
        byte_cnt <= byte_cnt + 32'd1;
        lock     <= 1'b1;
        // the next expected byte always follows the one just seen, which also resyncs after a glitch
        exp_byte <= rd_data + DATA_W'(1);
        if (lock && rd_data != exp_byte) begin
          err <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Randomized bench for fifo_rd_checker: behavioural FIFO, scoreboard and stream-rule model.
`timescale 1ns/1ps
module tb_fifo_rd_checker;
  localparam int DATA_W = 8, ERR_CNT_W = 16, BURST_MAX = 16, COOL_CYC = 4, TIMEOUT_CYC = 1024;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b0;
  logic        almost_full = 1'b0;
  logic        almost_empty = 1'b1;
  logic        empty = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_en, dout_vld, err, timeout;
  logic [7:0]  dout;
  logic [15:0] err_cnt;
  logic [31:0] byte_cnt;

  always #10 clk_50M = ~clk_50M;

  fifo_rd_checker #(
    .DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W), .BURST_MAX(BURST_MAX),
    .COOL_CYC(COOL_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .almost_full(almost_full), .almost_empty(almost_empty),
    .empty(empty), .rd_data(rd_data), .rd_en(rd_en), .dout(dout), .dout_vld(dout_vld),
    .err(err), .err_cnt(err_cnt), .byte_cnt(byte_cnt), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] sb[$];
  int         runs[$];
  int         ae_th = -1;
  bit         pop_pending, g1, g2, grant;
  int         run_len, gap, last_gap, n_grant;

  bit          m_lock, m_err;
  logic [7:0]  m_exp;
  int unsigned m_err_cnt;
  logic [31:0] m_bytes;

  function automatic void model_byte(input logic [7:0] b);
    m_bytes = m_bytes + 32'd1;
    if (m_lock && b != m_exp) begin
      m_err = 1'b1;
      if (m_err_cnt < 65535) m_err_cnt++;
    end
    m_lock = 1'b1;
    m_exp  = 8'(b + 8'd1);
  endfunction

  always @(negedge clk_50M) begin
    if (!rst) begin
      pop_pending = 1'b0; g1 = 1'b0; g2 = 1'b0; run_len = 0; gap = 1000;
    end else begin
      if (pop_pending) begin
        if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
        else begin
          rd_data = q.pop_front();
          sb.push_back(rd_data);
        end
      end
      chk("dout_vld", 32'(dout_vld), 32'(g2));
      if (g2) begin
        if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
        else begin
          chk("dout", 32'(dout), 32'(sb[0]));
          model_byte(sb.pop_front());
        end
      end
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
      chk("byte_cnt", byte_cnt, m_bytes);
    end
    empty        = (q.size() == 0);
    almost_empty = (q.size() <= ae_th);
    #1;
    grant = rst && rd_en;
    if (rst) begin
      chk("rd_en_gate", 32'(rd_en & empty), 32'd0);
      if (grant) begin
        if (run_len == 0 && gap < 1000) begin
          chk("cool_gap_min", 32'(gap >= COOL_CYC + 1), 32'd1);
          last_gap = gap;
        end
        run_len++;
        n_grant++;
        gap = 0;
        chk("burst_len", 32'(run_len <= BURST_MAX), 32'd1);
      end else begin
        if (run_len > 0) runs.push_back(run_len);
        run_len = 0;
        if (gap < 1000) gap++;
      end
    end
    pop_pending = grant;
    g2 = g1;
    g1 = grant;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #2;
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) q.push_back(8'(start + 8'(i)));
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (q.size() == 0 && sb.size() == 0 && !g1 && !g2 && run_len == 0) break;
      tick(1);
    end
    chk("drain_done", 32'(i < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    almost_full = 1'b0;
    ae_th = -1;
    q.delete(); sb.delete(); runs.delete();
    m_lock = 1'b0; m_err = 1'b0; m_exp = 8'h00; m_err_cnt = 0; m_bytes = 32'd0;
    rd_data = 8'h00; n_grant = 0; last_gap = 0;
    tick(3);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_byte_cnt", byte_cnt, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat, n, total;
    logic [7:0] b, st;

    // data waiting but almost_full low: nothing may be read
    do_reset();
    push_seq(8'h00, 16);
    tick(500);
    chk("idle_no_grant", 32'(n_grant), 32'd0);
    chk("idle_byte_cnt", byte_cnt, 32'd0);
    chk("idle_dout_vld", 32'(dout_vld), 32'd0);

    almost_full = 1'b1;
    lat = 0;
    while (!rd_en && lat < 20) begin tick(1); lat++; end
    chk("af_to_rd_lat", 32'(lat >= 2 && lat <= 3), 32'd1);
    drain(300);
    almost_full = 1'b0;
    chk("fill_byte_cnt", byte_cnt, 32'd16);
    chk("fill_err", 32'(err), 32'd0);
    chk("fill_runs", 32'(runs.size() == 1 && runs[0] == 16), 32'd1);

    // wrap 0xFF -> 0x00, then 0x02 must still be the expected next byte
    do_reset();
    q.push_back(8'hFE); q.push_back(8'hFF); q.push_back(8'h00); q.push_back(8'h01);
    almost_full = 1'b1;
    drain(300);
    q.push_back(8'h02);
    drain(300);
    almost_full = 1'b0;
    chk("wrap_err", 32'(err), 32'd0);
    chk("wrap_bytes", byte_cnt, 32'd5);

    // a glitch, resync, then a second glitch
    do_reset();
    q.push_back(8'h10); q.push_back(8'h11); q.push_back(8'h15); q.push_back(8'h16);
    almost_full = 1'b1;
    drain(300);
    chk("glitch1_err", 32'(err), 32'd1);
    chk("glitch1_cnt", 32'(err_cnt), 32'd1);
    q.push_back(8'h17); q.push_back(8'h30); q.push_back(8'h31);
    drain(300);
    almost_full = 1'b0;
    chk("glitch2_cnt", 32'(err_cnt), 32'd2);

    // empty ends a burst; next burst waits out the cool-down
    do_reset();
    push_seq(8'h20, 5);
    almost_full = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin tick(1); n++; end
    tick(2);
    push_seq(8'h25, 3);
    drain(300);
    almost_full = 1'b0;
    chk("empty_runs", 32'(runs.size() == 2 && runs[0] == 5 && runs[1] == 3), 32'd1);
    chk("empty_gap", 32'(last_gap), 32'(COOL_CYC + 2));
    chk("empty_bytes", byte_cnt, 32'd8);

    // burst limit splits a long fill
    do_reset();
    push_seq(8'h40, 20);
    almost_full = 1'b1;
    drain(400);
    almost_full = 1'b0;
    chk("bmax_runs", 32'(runs.size() == 2 && runs[0] == 16 && runs[1] == 4), 32'd1);
    chk("bmax_gap", 32'(last_gap), 32'(COOL_CYC + 1));

    // almost_empty and burst limit coincide on the 16th read
    do_reset();
    push_seq(8'h80, 20);
    ae_th = 5;
    almost_full = 1'b1;
    drain(600);
    almost_full = 1'b0;
    chk("coinc_runs", 32'(runs.size() == 5 && runs[0] == 16 && runs[4] == 1), 32'd1);
    chk("coinc_bytes", byte_cnt, 32'd20);

    // randomized fills with occasional corrupted bytes
    do_reset();
    total = 0;
    for (int r = 0; r < 10; r++) begin
      n  = int'($urandom_range(1, 40));
      st = 8'($urandom);
      for (int i = 0; i < n; i++) begin
        b = 8'(st + 8'(i));
        if ($urandom_range(0, 7) == 0) b = 8'($urandom);
        q.push_back(b);
      end
      total += n;
      ae_th = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
      almost_full = 1'b1;
      drain(2000);
      almost_full = 1'b0;
      tick(int'($urandom_range(0, 10)));
    end
    chk("rand_total", byte_cnt, 32'(total));

    // fill-wait watchdog
    do_reset();
    push_seq(8'h60, 3);
    tick(1000);
    chk("wd_early_timeout", 32'(timeout), 32'd0);
    chk("wd_early_bytes", byte_cnt, 32'd0);
`ifdef FIFO_CHK_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 100) begin tick(1); n++; end
    chk("wd_timeout_set", 32'(timeout), 32'd1);
    drain(300);
    chk("wd_drained", byte_cnt, 32'd3);
    chk("wd_sticky", 32'(timeout), 32'd1);
`else
    tick(200);
    chk("wd_off_timeout", 32'(timeout), 32'd0);
    chk("wd_off_bytes", byte_cnt, 32'd0);
    almost_full = 1'b1;
    drain(300);
    almost_full = 1'b0;
    chk("wd_off_drained", byte_cnt, 32'd3);
`endif

    // reset asserted in the middle of a burst
    do_reset();
    q.push_back(8'h00); q.push_back(8'h55);
    push_seq(8'h56, 14);
    almost_full = 1'b1;
    n = 0;
    while (!rd_en && n < 20) begin tick(1); n++; end
    chk("mid_rd_seen", 32'(rd_en), 32'd1);
    tick(4);
    chk("mid_pre_err", 32'(err), 32'd1);
    chk("mid_pre_vld", 32'(dout_vld), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rst_vld", 32'(dout_vld), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_byte_cnt", byte_cnt, 32'd0);
    do_reset();
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
